// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encodings and IF/ID record for the fetch stage.
package fetch_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_FILL = 2'd0;
  localparam fetch_state_t S_RUN  = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control in, imem address/data, IF/ID outputs.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if #(parameter int IMEM_AW = 8);

  logic               stall;
  logic               br_taken;
  logic [31:0]        br_target;
  logic [IMEM_AW-1:0] inst_addr;
  logic [31:0]        inst_in;
  logic [31:0]        pc_out;
  logic [31:0]        inst_out;
  logic               valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        bubble_cnt;
`endif

  modport master (
    input  stall, br_taken, br_target, inst_in,
`ifdef FETCH_PERF_CNT_EN
    output fetch_cnt, bubble_cnt,
`endif
    output inst_addr, pc_out, inst_out, valid_out
  );

  modport slave (
    output stall, br_taken, br_target, inst_in,
`ifdef FETCH_PERF_CNT_EN
    input  fetch_cnt, bubble_cnt,
`endif
    input  inst_addr, pc_out, inst_out, valid_out
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register; bubble has priority over load, neither means hold.
import fetch_stage_pkg::*;

module ifid_reg #(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [PC_W-1:0] pc_d,
  input  logic [31:0]     inst_d,
  output ifid_t           q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (bubble) begin
      q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (load) begin
      q <= '{pc: pc_d, inst: inst_d, valid: 1'b1};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/FSM control against a 1-cycle synchronous imem.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  fetch_state_t    state, state_d;
  logic [PC_W-1:0] pc_f, pc_f_d;
  logic [PC_W-1:0] pc_q, pc_q_d;
  logic            load_valid;
  logic            load_bubble;
  ifid_t           ifid_q;

  // While stalled, re-issue pc_q so inst_in keeps presenting mem[pc_q].
  assign bus.inst_addr = (bus.stall && !bus.br_taken) ? pc_q[IMEM_AW-1:0]
                                                      : pc_f[IMEM_AW-1:0];

  always_comb begin
    state_d     = state;
    pc_f_d      = pc_f;
    pc_q_d      = pc_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    if (bus.br_taken) begin
      pc_f_d      = bus.br_target;
      load_bubble = 1'b1;
      state_d     = S_FILL;
    end else if (bus.stall) begin
      // A stall in S_FILL just waits; nothing useful is in flight yet.
      if (state != S_FILL) state_d = S_HOLD;
    end else begin
      pc_q_d  = pc_f;
      pc_f_d  = pc_f + 32'd1;
      state_d = S_RUN;
      case (state)
        S_FILL:  load_bubble = 1'b1;
        default: load_valid  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
      pc_f  <= RESET_PC;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_d;
      pc_f  <= pc_f_d;
      pc_q  <= pc_q_d;
    end
  end

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_valid),
    .bubble (load_bubble),
    .pc_d   (pc_q),
    .inst_d (bus.inst_in),
    .q      (ifid_q)
  );

  assign bus.pc_out    = ifid_q.pc;
  assign bus.inst_out  = ifid_q.inst;
  assign bus.valid_out = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_valid && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset, wrap and counter sequences.
module tb_fetch_stage;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   exp_fetch;
  int   exp_bubble;
  vec_t vecs[20];
  logic [31:0] mem [256];

  fetch_stage_if #(.IMEM_AW(8)) bus_a ();
  fetch_stage_if #(.IMEM_AW(8)) bus_b ();

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(8), .NOP_INST(32'h0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  fetch_stage #(.RESET_PC(32'd254), .IMEM_AW(8), .NOP_INST(32'h0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories: data returns the cycle after the address.
  always @(posedge clk) begin
    bus_a.inst_in <= mem[bus_a.inst_addr];
    bus_b.inst_in <= mem[bus_b.inst_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_pc,
                             input logic [31:0] exp_inst);
    logic bad;
    tests_run++;
    bad = (bus_a.valid_out !== exp_valid) || (bus_a.inst_out !== exp_inst);
    if (exp_valid) bad = bad || (bus_a.pc_out !== exp_pc);
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL %s: got v=%0b pc=%0d inst=%h want v=%0b pc=%0d inst=%h",
               name, bus_a.valid_out, bus_a.pc_out, bus_a.inst_out, exp_valid, exp_pc, exp_inst);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] tgt);
    bus_a.stall     = stall;
    bus_a.br_taken  = br;
    bus_a.br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_fetch    = 0;
    exp_bubble   = 0;
    for (int k = 0; k < 256; k++) mem[k] = k * 16;

    // stall, br, tgt, exp_valid, exp_pc, exp_inst
    vecs[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'h000};
    vecs[1]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd0,  32'h000};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd1,  32'h010};
    vecs[3]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd2,  32'h020};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd3,  32'h030};
    vecs[5]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  32'h040};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd5,  32'h050};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd5,  32'h050};
    vecs[8]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd5,  32'h050};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd5,  32'h050};
    vecs[10] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd6,  32'h060};
    vecs[11] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd7,  32'h070};
    vecs[12] = '{1'b0, 1'b1, 32'd40, 1'b0, 32'd0,  32'h000};
    vecs[13] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'h000};
    vecs[14] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd40, 32'h280};
    vecs[15] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd41, 32'h290};
    vecs[16] = '{1'b1, 1'b1, 32'd12, 1'b0, 32'd0,  32'h000};
    vecs[17] = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0,  32'h000};
    vecs[18] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12, 32'h0C0};
    vecs[19] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd13, 32'h0D0};

    bus_a.stall = 1'b0; bus_a.br_taken = 1'b0; bus_a.br_target = '0;
    bus_b.stall = 1'b0; bus_b.br_taken = 1'b0; bus_b.br_target = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 1'b0, 32'd0, 32'h0);
    checkValue("reset_pc_out", bus_a.pc_out, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_inst);
      if (!vecs[i].stall || vecs[i].br) begin
        if (vecs[i].exp_valid) exp_fetch++;
        else exp_bubble++;
      end
    end

`ifdef FETCH_PERF_CNT_EN
    checkValue("fetch_cnt", bus_a.fetch_cnt, exp_fetch);
    checkValue("bubble_cnt", bus_a.bubble_cnt, exp_bubble);
`endif

    // Reset pulse in the middle of a stall must wipe the held instruction.
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("stall_hold_a", 1'b1, 32'd13, 32'h0D0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("stall_hold_b", 1'b1, 32'd13, 32'h0D0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 32'd0, 32'h0);
    checkValue("async_reset_pc", bus_a.pc_out, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkValue("reset_fetch_cnt", bus_a.fetch_cnt, 32'd0);
    checkValue("reset_bubble_cnt", bus_a.bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    bus_a.stall = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("refill_bubble", 1'b0, 32'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("refill_pc0", 1'b1, 32'd0, 32'h000);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("refill_pc1", 1'b1, 32'd1, 32'h010);

    // Address wrap on the instance that starts at 254.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("wrap_addr0", 32'(bus_b.inst_addr), 32'd254);
    @(posedge clk); #1;
    checkValue("wrap_addr1", 32'(bus_b.inst_addr), 32'd255);
    checkValue("wrap_bubble", 32'(bus_b.valid_out), 32'd0);
    @(posedge clk); #1;
    checkValue("wrap_addr2", 32'(bus_b.inst_addr), 32'd0);
    checkValue("wrap_pc254", bus_b.pc_out, 32'd254);
    checkValue("wrap_inst254", bus_b.inst_out, 32'hFE0);
    @(posedge clk); #1;
    checkValue("wrap_addr3", 32'(bus_b.inst_addr), 32'd1);
    checkValue("wrap_pc255", bus_b.pc_out, 32'd255);
    @(posedge clk); #1;
    checkValue("wrap_pc256", bus_b.pc_out, 32'd256);
    checkValue("wrap_inst256", bus_b.inst_out, 32'h000);
    checkValue("wrap_valid256", 32'(bus_b.valid_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word address fetched first after reset.
REQ-002 Parameter IMEM_AW, default 8: instruction-memory word-address width.
REQ-003 Parameter NOP_INST, default 32'h0000_0000: encoding driven on inst_out during bubbles.
REQ-004 clk  in  1: single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 stall  in  1: hazard hold; freezes PC and the IF/ID register.
REQ-007 br_taken  in  1: redirect request from EX; squashes in-flight fetch.
REQ-008 br_target  in  32: word address to fetch when br_taken=1.
REQ-009 inst_addr  out  IMEM_AW: address to the synchronous instruction memory.
REQ-010 inst_in  in  32: instruction memory read data; valid the cycle after inst_addr.
REQ-011 pc_out  out  32: IF/ID register, PC of inst_out.
REQ-012 inst_out  out  32: IF/ID register, fetched instruction.
REQ-013 valid_out  out  1: IF/ID register, 1 = inst_out is a real instruction, 0 = bubble.

Function
REQ-014 PC is word-addressed; sequential increment is +1, modulo 2^32.
REQ-015 The block SHALL hold pc_f (address being issued) and pc_q (address whose data arrives on inst_in this cycle).
REQ-016 FSM states: S_FILL (inst_in not yet valid), S_RUN (inst_in = mem[pc_q]), S_HOLD (stalled, data re-read).
REQ-017 inst_addr = pc_f[IMEM_AW-1:0] in S_FILL/S_RUN with stall=0; inst_addr = pc_q[IMEM_AW-1:0] whenever stall=1 and br_taken=0, so inst_in keeps returning mem[pc_q].
REQ-018 S_FILL, no br_taken: pc_q<=pc_f, pc_f<=pc_f+1, IF/ID loads bubble (valid_out=0, inst_out=NOP_INST), next S_RUN.
REQ-019 S_RUN, stall=0, br_taken=0: IF/ID <= {pc_q, inst_in, 1}; pc_q<=pc_f; pc_f<=pc_f+1; stay S_RUN.
REQ-020 S_RUN or S_HOLD, stall=1, br_taken=0: IF/ID, pc_f, pc_q hold; next S_HOLD.
REQ-021 S_HOLD, stall=0: behave as REQ-019 (inst_in is mem[pc_q] from the re-issue); next S_RUN.
REQ-022 br_taken=1 in any state SHALL override stall: pc_f<=br_target, IF/ID <= bubble, next S_FILL; inst_addr this cycle is don't-care.
REQ-023 First valid instruction appears on IF/ID 2 cycles after reset release or after the redirect cycle.
REQ-024 inst_addr wraps 255->0 while pc_f continues counting in 32 bits.
REQ-025 Throughput: one valid instruction per cycle in steady S_RUN.

Reset
REQ-026 rst_n=0 SHALL immediately force pc_f=RESET_PC, pc_q=RESET_PC, state=S_FILL, pc_out=0, inst_out=NOP_INST, valid_out=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; no instruction from before reset appears afterward.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt[31:0] (incremented on each IF/ID load with valid=1) and bubble_cnt[31:0] (incremented on each IF/ID load with valid=0); both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-029 Without FETCH_PERF_CNT_EN, these ports and counters are absent; all other behaviour is identical.

Structure
REQ-030 Shared package holds the state enum (S_FILL, S_RUN, S_HOLD), the NOP_INST default and the PC width constant.
REQ-031 One sub-module, ifid_reg (pc/inst/valid with load and bubble controls), is natural; the FSM and PC logic stay in fetch_stage.

Verification
REQ-032 Reset release, mem[k]=k*16, no stall -> valid_out=0 for 1 cycle, then pc_out=0,1,2... with inst_out=0x00,0x10,0x20 on consecutive cycles.
REQ-033 stall=1 for 3 cycles while pc_out=5 -> pc_out=5, inst_out=mem[5] held; after release pc_out=6 with inst_out=mem[6], no skip or duplicate.
REQ-034 br_taken=1, br_target=40 while pc_out=7 -> next cycle valid_out=0; following cycle valid_out=0; then pc_out=40, inst_out=mem[40].
REQ-035 br_taken=1 and stall=1 together, br_target=12 -> redirect wins; pc_out=12 appears 2 cycles later.
REQ-036 RESET_PC=254, run 4 cycles -> inst_addr 254,255,0,1; pc_out reaches 256 with inst_out=mem[0].
REQ-037 rst_n pulsed low during stall -> outputs go to reset values immediately; the refill starts from RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
